po2_dot_sequencer: RTL and testbench

Sequencer and accumulator for one power-of-two multiply lane. A single `start` runs a dot product of length `len`. For each element the block fetches the activation and the encoded weight from 1-cycle-latency memories, then either skips the element (zero weight) or issues it to the po2 multiply unit with a one-cycle restart pulse and waits for its `result_v`. Products are summed in a widened accumulator, and the total is presented on a valid/ready output. It sits between the layer's activation/weight buffers and the po2 multiply lane.

---
 rtl/po2_dot_sequencer_if.sv | 57 +++++
 rtl/po2_dot_sequencer.sv | 175 +++++++++++++++++
 tb/tb_po2_dot_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/po2_dot_sequencer_if.sv
// Bundle between the dot-product sequencer and its neighbours: start/len
// control, activation/weight buffer read port, po2 multiply lane operands
// and the valid/ready result port. The master side is the sequencer.
interface po2_dot_sequencer_if #(
    parameter int W = 16,
    parameter int N = 8
);
    localparam int AW    = $clog2(N);
    localparam int ACC_W = 2 * W + $clog2(N);

    // run control
    logic             start;
    logic [AW:0]      len;
    logic             busy;

    // activation / weight buffers (1-cycle read latency)
    logic [AW-1:0]    addr;
    logic [W-1:0]     rd_inp;
    logic             rd_zero;
    logic             rd_neg;
    logic [W-1:0]     rd_log2;

    // po2 multiply lane
    logic             mul_restart;
    logic [W-1:0]     mul_inp;
    logic             mul_zero;
    logic             mul_neg;
    logic [W-1:0]     mul_log2;
    logic [2*W-1:0]   mul_result;
    logic             mul_result_v;

    // result port
    logic [ACC_W-1:0] out_data;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  start, len,
        input  rd_inp, rd_zero, rd_neg, rd_log2,
        input  mul_result, mul_result_v,
        input  out_ready,
        output busy, addr,
        output mul_restart, mul_inp, mul_zero, mul_neg, mul_log2,
        output out_data, out_err, out_valid
    );

    modport slave (
        output start, len,
        output rd_inp, rd_zero, rd_neg, rd_log2,
        output mul_result, mul_result_v,
        output out_ready,
        input  busy, addr,
        input  mul_restart, mul_inp, mul_zero, mul_neg, mul_log2,
        input  out_data, out_err, out_valid
    );
endinterface

// File: rtl/po2_dot_sequencer.sv
// Dot-product sequencer for one po2 multiply lane. Walks len elements,
// fetches activation + encoded weight, skips zero weights, issues the rest
// to the multiply unit with a one-cycle restart pulse, accumulates the
// products in a widened accumulator and hands the sum out on valid/ready.
// A product that does not arrive within TIMEOUT wait cycles is dropped and
// flagged through the sticky error bit for that run.
module po2_dot_sequencer #(
    parameter int W       = 16,
    parameter int I       = 4,
    parameter int N       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    po2_dot_sequencer_if.master   bus
);
    localparam int AW    = $clog2(N);
    localparam int ACC_W = 2 * W + $clog2(N);
    localparam int WC_W  = $clog2(TIMEOUT + 1);

    // Catch nonsensical parameterisations at elaboration time.
    generate
        if (I < 1 || I >= W || TIMEOUT < 1 || N < 2) begin : g_bad_param
            $error("po2_dot_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     idx_reg,   idx_next;
    logic [AW:0]       len_reg,   len_next;
    logic [ACC_W-1:0]  acc_reg,   acc_next;
    logic              err_reg,   err_next;
    logic [WC_W-1:0]   wcnt_reg,  wcnt_next;
    logic [W-1:0]      inp_reg,   inp_next;
    logic              zero_reg,  zero_next;
    logic              neg_reg,   neg_next;
    logic [W-1:0]      log2_reg,  log2_next;

    logic [AW:0]       len_clamped;
    logic              last_elem;
    logic              advance;
    logic [ACC_W-1:0]  prod_ext;

    // Lengths beyond the buffer depth are treated as a full-length run.
    assign len_clamped = (bus.len > (AW + 1)'(N)) ? (AW + 1)'(N) : bus.len;
    assign last_elem   = ({1'b0, idx_reg} == (len_reg - (AW + 1)'(1)));
    // Product is Q(2I).(2W-2I); sign-extend into the accumulator width.
    assign prod_ext    = ACC_W'($signed(bus.mul_result));

    // State and datapath registers; asynchronous reset aborts any run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            len_reg   <= '0;
            acc_reg   <= '0;
            err_reg   <= 1'b0;
            wcnt_reg  <= '0;
            inp_reg   <= '0;
            zero_reg  <= 1'b0;
            neg_reg   <= 1'b0;
            log2_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            len_reg   <= len_next;
            acc_reg   <= acc_next;
            err_reg   <= err_next;
            wcnt_reg  <= wcnt_next;
            inp_reg   <= inp_next;
            zero_reg  <= zero_next;
            neg_reg   <= neg_next;
            log2_reg  <= log2_next;
        end
    end

    // Next-state and datapath update for the element walk.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        len_next   = len_reg;
        acc_next   = acc_reg;
        err_next   = err_reg;
        wcnt_next  = wcnt_reg;
        inp_next   = inp_reg;
        zero_next  = zero_reg;
        neg_next   = neg_reg;
        log2_next  = log2_reg;
        advance    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    acc_next  = '0;
                    idx_next  = '0;
                    err_next  = 1'b0;
                    wcnt_next = '0;
                    len_next  = len_clamped;
                    state_next = (len_clamped == '0) ? S_EMIT : S_FETCH;
                end
            end
            S_FETCH: begin
                // addr already shows idx; memories answer during LOAD.
                state_next = S_LOAD;
            end
            S_LOAD: begin
                inp_next  = bus.rd_inp;
                zero_next = bus.rd_zero;
                neg_next  = bus.rd_neg;
                log2_next = bus.rd_log2;
                if (bus.rd_zero) begin
                    advance = 1'b1;
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_next  = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // result_v is only trusted here; during ISSUE it still
                // reflects the previous product.
                if (bus.mul_result_v) begin
                    acc_next = acc_reg + prod_ext;
                    advance  = 1'b1;
                end else if (wcnt_reg == WC_W'(TIMEOUT - 1)) begin
                    err_next = 1'b1;
                    advance  = 1'b1;
                end else begin
                    wcnt_next = wcnt_reg + WC_W'(1);
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (advance) begin
            if (last_elem) begin
                state_next = S_EMIT;
            end else begin
                idx_next   = idx_reg + AW'(1);
                state_next = S_FETCH;
            end
        end
    end

    // Outputs are decoded straight from registers.
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.addr        = idx_reg;
    assign bus.mul_restart = (state_reg == S_ISSUE);
    assign bus.mul_inp     = inp_reg;
    assign bus.mul_zero    = zero_reg;
    assign bus.mul_neg     = neg_reg;
    assign bus.mul_log2    = log2_reg;
    assign bus.out_data    = acc_reg;
    assign bus.out_err     = err_reg;
    assign bus.out_valid   = (state_reg == S_EMIT);

endmodule

// File: tb/tb_po2_dot_sequencer.sv
// Directed bench for po2_dot_sequencer: buffer model with 1-cycle reads,
// po2 multiplier model with fixed latency 3, hand-computed expectations.
module tb_po2_dot_sequencer;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int AW = $clog2(N);
    localparam int K  = 3;

    logic clk;
    logic rst;

    po2_dot_sequencer_if #(.W(W), .N(N)) bus ();

    po2_dot_sequencer #(.W(W), .I(4), .N(N), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // buffer contents
    logic [W-1:0] act_m  [0:N-1];
    logic         zero_m [0:N-1];
    logic         neg_m  [0:N-1];
    logic [W-1:0] log2_m [0:N-1];

    // buffer model: registered read of addr
    always @(posedge clk) begin
        bus.rd_inp  <= act_m[bus.addr];
        bus.rd_zero <= zero_m[bus.addr];
        bus.rd_neg  <= neg_m[bus.addr];
        bus.rd_log2 <= log2_m[bus.addr];
    end

    // multiplier model: result_v rises K cycles after ISSUE, held until next restart
    int   no_result_elem;
    int   mcnt;
    logic armed;
    logic model_rv;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_rv <= 1'b0;
            armed    <= 1'b0;
            mcnt     <= 0;
        end else if (bus.mul_restart) begin
            model_rv <= 1'b0;
            armed    <= (int'(bus.addr) != no_result_elem);
            mcnt     <= K - 1;
        end else if (armed && mcnt == 1) begin
            model_rv <= 1'b1;
            armed    <= 1'b0;
        end else if (armed) begin
            mcnt <= mcnt - 1;
        end
    end
    assign bus.mul_result_v = model_rv;

    // product = inp * 2^(-log2), Q4.12 -> Q8.24
    logic signed [2*W-1:0] prod;
    always_comb begin
        prod = 32'(signed'(bus.mul_inp)) <<< 12;
        prod = prod >>> bus.mul_log2;
        if (bus.mul_neg) prod = -prod;
    end
    assign bus.mul_result = prod;

    // monitors
    int         pulse_cnt;
    int         double_cnt;
    int         addr_changes;
    int         nvis;
    logic       seen;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] last_vis;
    logic [AW-1:0] visits [0:15];
    logic       prev_restart;
    always @(posedge clk) begin
        if (bus.mul_restart) pulse_cnt++;
        if (bus.mul_restart && prev_restart) double_cnt++;
        prev_restart = bus.mul_restart;
        if (bus.addr != prev_addr) addr_changes++;
        prev_addr = bus.addr;
        if (bus.busy && (!seen || bus.addr != last_vis)) begin
            if (nvis < 16) visits[nvis] = bus.addr;
            nvis++;
            last_vis = bus.addr;
            seen = 1'b1;
        end
    end

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_elem(input int i, input logic [W-1:0] a, input logic z,
                            input logic ng, input logic [W-1:0] l2);
        act_m[i]  = a;
        zero_m[i] = z;
        neg_m[i]  = ng;
        log2_m[i] = l2;
    endtask

    task automatic clear_mon();
        pulse_cnt    = 0;
        double_cnt   = 0;
        addr_changes = 0;
        nvis         = 0;
        seen         = 1'b0;
    endtask

    // Launch a run and wait (bounded) for out_valid; cyc = cycles after start edge.
    task automatic launch(input int l, input string name, output int cyc);
        @(negedge clk);
        clear_mon();
        bus.len   = (AW + 1)'(l);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        check_eq({name, "_busy"}, {63'd0, bus.busy}, 64'd1);
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        $display("run %s len=%0d data=0x%0h err=%0d cycles=%0d pulses=%0d",
                 name, l, bus.out_data, bus.out_err, cyc, pulse_cnt);
    endtask

    // out_ready is high: transfer happens at the next edge, then IDLE.
    task automatic finish_xfer(input string name);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq({name, "_idle"}, {63'd0, bus.busy}, 64'd0);
        check_eq({name, "_vdrop"}, {63'd0, bus.out_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [63:0] held;
        n_checks = 0;
        n_fail = 0;
        no_result_elem = -1;
        prev_addr = '0;
        prev_restart = 1'b0;
        last_vis = '0;
        clear_mon();
        bus.start = 1'b0;
        bus.len = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_elem(i, 16'h1000, 1'b0, 1'b0, 16'd0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",    {63'd0, bus.busy},        64'd0);
        check_eq("rst_valid",   {63'd0, bus.out_valid},   64'd0);
        check_eq("rst_err",     {63'd0, bus.out_err},     64'd0);
        check_eq("rst_restart", {63'd0, bus.mul_restart}, 64'd0);
        check_eq("rst_data",    64'(bus.out_data),        64'd0);
        check_eq("rst_addr",    64'(bus.addr),            64'd0);
        check_eq("rst_mulinp",  64'(bus.mul_inp),         64'd0);
        rst = 1'b0;
        @(negedge clk);

        // mixed weights: +0.5, -0.25, zero
        set_elem(0, 16'h1000, 1'b0, 1'b0, 16'd1);
        set_elem(1, 16'h1000, 1'b0, 1'b1, 16'd2);
        set_elem(2, 16'h1000, 1'b1, 1'b0, 16'd0);
        launch(3, "mixed", cyc);
        check_eq("mixed_data",   64'(bus.out_data), 64'h0040_0000);
        check_eq("mixed_err",    {63'd0, bus.out_err}, 64'd0);
        check_eq("mixed_pulses", 64'(pulse_cnt), 64'd2);
        check_eq("mixed_cycles", 64'(cyc), 64'd15);
        finish_xfer("mixed");

        // empty run
        launch(0, "empty", cyc);
        check_eq("empty_cycles", 64'(cyc), 64'd1);
        check_eq("empty_data",   64'(bus.out_data), 64'd0);
        check_eq("empty_pulses", 64'(pulse_cnt), 64'd0);
        check_eq("empty_addr",   64'(addr_changes), 64'd0);
        finish_xfer("empty");

        // full length, len clamps to N
        for (int i = 0; i < N; i++) set_elem(i, 16'h1000, 1'b0, 1'b0, 16'd0);
        launch(12, "full", cyc);
        check_eq("full_data",   64'(bus.out_data), 64'h0800_0000);
        check_eq("full_cycles", 64'(cyc), 64'd49);
        check_eq("full_pulses", 64'(pulse_cnt), 64'd8);
        check_eq("full_nvis",   64'(nvis), 64'd8);
        for (int i = 0; i < N; i++) check_eq($sformatf("full_visit%0d", i), 64'(visits[i]), 64'(i));
        finish_xfer("full");

        // backpressure with start pulses in EMIT and on the transfer cycle
        bus.out_ready = 1'b0;
        launch(1, "bp", cyc);
        held = 64'(bus.out_data);
        check_eq("bp_data", held, 64'h0100_0000);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i % 2 == 0);
            bus.len = 4'd3;
            @(negedge clk);
            check_eq($sformatf("bp_valid%0d", i), {63'd0, bus.out_valid}, 64'd1);
            check_eq($sformatf("bp_hold%0d", i),  64'(bus.out_data), 64'h0100_0000);
            check_eq($sformatf("bp_busy%0d", i),  {63'd0, bus.busy}, 64'd1);
        end
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("bp_idle",  {63'd0, bus.busy}, 64'd0);
        check_eq("bp_vdrop", {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk);
        check_eq("bp_still_idle", {63'd0, bus.busy}, 64'd0);

        // timeout on element 1
        no_result_elem = 1;
        launch(3, "tmo", cyc);
        check_eq("tmo_err",    {63'd0, bus.out_err}, 64'd1);
        check_eq("tmo_data",   64'(bus.out_data), 64'h0200_0000);
        check_eq("tmo_cycles", 64'(cyc), 64'd31);
        finish_xfer("tmo");
        no_result_elem = -1;

        // reset during WAIT
        @(negedge clk);
        clear_mon();
        bus.len = 4'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.mul_restart && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rmid_issue_seen", {63'd0, bus.mul_restart}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rmid_busy",    {63'd0, bus.busy},        64'd0);
        check_eq("rmid_valid",   {63'd0, bus.out_valid},   64'd0);
        check_eq("rmid_restart", {63'd0, bus.mul_restart}, 64'd0);
        check_eq("rmid_data",    64'(bus.out_data),        64'd0);
        check_eq("rmid_mulinp",  64'(bus.mul_inp),         64'd0);
        check_eq("rmid_addr",    64'(bus.addr),            64'd0);
        @(negedge clk);
        rst = 1'b0;
        set_elem(0, 16'h1000, 1'b0, 1'b0, 16'd1);
        launch(1, "after_rst", cyc);
        check_eq("after_rst_data",   64'(bus.out_data), 64'h0080_0000);
        check_eq("after_rst_err",    {63'd0, bus.out_err}, 64'd0);
        check_eq("after_rst_cycles", 64'(cyc), 64'd7);
        check_eq("restart_double",   64'(double_cnt), 64'd0);
        finish_xfer("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
